// File: rtl/lock_pkg.sv
// Shared types and sizing helpers for the sequential keypad lock.
package lock_pkg;

   typedef enum logic [1:0] {
      StEntry,
      StOpen,
      StLockout
   } lockState_e;

   // Bits needed to hold every value from 0 to maxVal inclusive.
   function automatic int unsigned cntWidth(input int unsigned maxVal);
      return (maxVal < 1) ? 1 : int'($clog2(maxVal + 1));
   endfunction

   function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that flags the last cycle of a timed window.
module lock_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   output logic             expire
);

   logic [WIDTH-1:0] countQ, countD;

   always_comb begin
      countD = countQ;
      if (load) begin
         countD = loadValue;
      end else if (countQ != '0) begin
         countD = countQ - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         countQ <= '0;
      end else begin
         countQ <= countD;
      end
   end

   assign expire = (countQ == WIDTH'(1));

endmodule

// File: rtl/seq_lock.sv
// Sequential keypad lock: on-the-fly code compare, timed open window, failure lockout and
// fire-alarm override. No digits are stored; only a sticky mismatch flag.
module seq_lock
   import lock_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 5,
   parameter int unsigned DIGIT_W     = 4,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCKOUT_CYC = 1000,
   parameter int unsigned UNLOCK_CYC  = 500
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            digit_valid,
   input  logic [DIGIT_W-1:0]              digit,
   input  logic                            clear,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   password,
   input  logic                            fire_alarm,
   output logic                            unlock,
   output logic                            locked_out,
   output logic                            attempt_fail,
   output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count
);

   localparam int unsigned CntW   = cntWidth(NUM_DIGITS);
   localparam int unsigned FailW  = cntWidth(MAX_TRIES);
   localparam int unsigned TimerW = cntWidth(maxOf(UNLOCK_CYC, LOCKOUT_CYC));

   lockState_e        stateQ, stateD;
   logic [CntW-1:0]   digitCountQ, digitCountD;
   logic              mismatchQ, mismatchD;
   logic [FailW-1:0]  failCntQ, failCntD;
   logic              attemptFailQ, attemptFailD;
   logic              timerLoad;
   logic [TimerW-1:0] timerValue;
   logic              timerExpire;
   logic [DIGIT_W-1:0] expDigit;

   lock_timer #(
      .WIDTH(TimerW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timerLoad),
      .loadValue(timerValue),
      .expire   (timerExpire)
   );

   // Digit 0 lives in the MSBs of the password.
   always_comb begin
      expDigit = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (digitCountQ == CntW'(i)) begin
            expDigit = password[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
         end
      end
   end

   always_comb begin
      stateD       = stateQ;
      digitCountD  = digitCountQ;
      mismatchD    = mismatchQ;
      failCntD     = failCntQ;
      attemptFailD = 1'b0;
      timerLoad    = 1'b0;
      timerValue   = '0;

      case (stateQ)
         StEntry: begin
            if (fire_alarm || clear) begin
               digitCountD = '0;
               mismatchD   = 1'b0;
            end else if (digit_valid) begin
               if (digitCountQ == CntW'(NUM_DIGITS - 1)) begin
                  digitCountD = '0;
                  mismatchD   = 1'b0;
                  if (!mismatchQ && (digit == expDigit)) begin
                     stateD     = StOpen;
                     failCntD   = '0;
                     timerLoad  = 1'b1;
                     timerValue = TimerW'(UNLOCK_CYC);
                  end else begin
                     attemptFailD = 1'b1;
                     if (failCntQ == FailW'(MAX_TRIES - 1)) begin
                        failCntD   = FailW'(MAX_TRIES);
                        stateD     = StLockout;
                        timerLoad  = 1'b1;
                        timerValue = TimerW'(LOCKOUT_CYC);
                     end else begin
                        failCntD = failCntQ + FailW'(1);
                     end
                  end
               end else begin
                  digitCountD = digitCountQ + CntW'(1);
                  mismatchD   = mismatchQ | (digit != expDigit);
               end
            end
         end
         StOpen: begin
            if (timerExpire) begin
               stateD      = StEntry;
               digitCountD = '0;
            end
         end
         StLockout: begin
            if (timerExpire) begin
               stateD   = StEntry;
               failCntD = '0;
            end
         end
         default: begin
            stateD = StEntry;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ       <= StEntry;
         digitCountQ  <= '0;
         mismatchQ    <= 1'b0;
         failCntQ     <= '0;
         attemptFailQ <= 1'b0;
      end else begin
         stateQ       <= stateD;
         digitCountQ  <= digitCountD;
         mismatchQ    <= mismatchD;
         failCntQ     <= failCntD;
         attemptFailQ <= attemptFailD;
      end
   end

   // The override path bypasses all state so the door opens in the alarm cycle itself.
   assign unlock       = fire_alarm | (stateQ == StOpen);
   assign locked_out   = (stateQ == StLockout);
   assign attempt_fail = attemptFailQ;
   assign digit_count  = digitCountQ;

endmodule

// File: tb/tb_seq_lock.sv
// Table-driven bench for seq_lock with a per-step expectation queue.
module tb_seq_lock;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        digit_valid = 1'b0;
   logic [3:0]  digit = 4'h0;
   logic        clear = 1'b0;
   logic [19:0] password = 20'h12345;
   logic        fire_alarm = 1'b0;
   logic        unlock;
   logic        locked_out;
   logic        attempt_fail;
   logic [2:0]  digit_count;

   seq_lock #(
      .NUM_DIGITS (5),
      .DIGIT_W    (4),
      .MAX_TRIES  (3),
      .LOCKOUT_CYC(8),
      .UNLOCK_CYC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_valid (digit_valid),
      .digit       (digit),
      .clear       (clear),
      .password    (password),
      .fire_alarm  (fire_alarm),
      .unlock      (unlock),
      .locked_out  (locked_out),
      .attempt_fail(attempt_fail),
      .digit_count (digit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       dv;
      logic [3:0] d;
      logic       clr;
      logic       fa;
      logic       r;
      logic       eU;
      logic       eL;
      logic       eA;
      logic [2:0] eC;
      logic       chkPre;
      logic       ePre;
   } vec_t;

   typedef struct {
      logic       eU;
      logic       eL;
      logic       eA;
      logic [2:0] eC;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int step, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   // Expected values describe outputs just after the edge that samples this step's inputs.
   task automatic add(input logic dv, input logic [3:0] d, input logic clr, input logic fa,
                      input logic r, input logic eU, input logic eL, input logic eA,
                      input int eC, input logic chkPre = 1'b0, input logic ePre = 1'b0);
      vec_t v;
      v.dv = dv; v.d = d; v.clr = clr; v.fa = fa; v.r = r;
      v.eU = eU; v.eL = eL; v.eA = eA; v.eC = 3'(eC);
      v.chkPre = chkPre; v.ePre = ePre;
      vecs.push_back(v);
   endtask

   task automatic idle(input logic eU, input logic eL);
      add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, eU, eL, 1'b0, 0);
   endtask

   task automatic resetStep();
      add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic enterCode(input logic [19:0] c, input logic fU, input logic fL,
                            input logic fA);
      for (int i = 0; i < 4; i++) begin
         add(1'b1, c[19-4*i -: 4], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i + 1);
      end
      add(1'b1, c[3:0], 1'b0, 1'b0, 1'b0, fU, fL, fA, 0);
   endtask

   task automatic ignoredCode(input logic [19:0] c, input logic eL);
      for (int i = 0; i < 5; i++) begin
         add(1'b1, c[19-4*i -: 4], 1'b0, 1'b0, 1'b0, 1'b0, eL, 1'b0, 0);
      end
   endtask

   task automatic openTail();
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
   endtask

   initial begin
      exp_t e;

      // Reset state.
      resetStep();

      // 1: correct code opens for exactly four cycles; digits ignored while open.
      enterCode(20'h12345, 1'b1, 1'b0, 1'b0);
      add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);

      // 2: one wrong middle digit.
      enterCode(20'h12945, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0);

      // 3: three failures -> 8-cycle lockout, correct code ignored, then accepted.
      resetStep();
      enterCode(20'h02345, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0);
      enterCode(20'h12346, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0);
      enterCode(20'h77777, 1'b0, 1'b1, 1'b1);
      ignoredCode(20'h12345, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      enterCode(20'h12345, 1'b1, 1'b0, 1'b0);
      openTail();

      // 4: clear aborts without a failure; clear beats a simultaneous digit.
      add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      enterCode(20'h12345, 1'b1, 1'b0, 1'b0);
      openTail();
      add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      enterCode(20'h12345, 1'b1, 1'b0, 1'b0);
      openTail();

      // 5: fire alarm clears a partial entry, then overrides during lockout.
      add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      add(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      enterCode(20'h12945, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0);
      enterCode(20'h12945, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0);
      enterCode(20'h12945, 1'b0, 1'b1, 1'b1);
      idle(1'b0, 1'b1);
      add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);

      // 6: reset in the second open cycle, then a fresh open.
      enterCode(20'h12345, 1'b1, 1'b0, 1'b0);
      idle(1'b1, 1'b0);
      resetStep();
      enterCode(20'h12345, 1'b1, 1'b0, 1'b0);
      openTail();

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         digit_valid = vecs[i].dv;
         digit       = vecs[i].d;
         clear       = vecs[i].clr;
         fire_alarm  = vecs[i].fa;
         rst         = vecs[i].r;
         e.eU = vecs[i].eU;
         e.eL = vecs[i].eL;
         e.eA = vecs[i].eA;
         e.eC = vecs[i].eC;
         expQ.push_back(e);
         if (vecs[i].chkPre) begin
            #1;
            check("unlock_same_cycle", i, 32'(unlock), 32'(vecs[i].ePre));
         end
         @(posedge clk);
         #1;
         e = expQ.pop_front();
         check("unlock", i, 32'(unlock), 32'(e.eU));
         check("locked_out", i, 32'(locked_out), 32'(e.eL));
         check("attempt_fail", i, 32'(attempt_fail), 32'(e.eA));
         check("digit_count", i, 32'(digit_count), 32'(e.eC));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
